// File: rtl/a800_sd_pkg.sv
// Shared types and constants for the Atari 800 ZPU <-> hps_io sector bridge.
package a800_sd_pkg;

  typedef enum logic [1:0] {IDLE, REQ, XFER} sd_state_t;

  // zpu_out2 control-word bit positions
  localparam int LBA_SEL = 0;
  localparam int BLK_RD  = 1;
  localparam int BLK_WR  = 2;
  localparam int DRV_LSB = 3;

  // zpu_in2 status-word bit positions
  localparam int ST_IO_DONE = 0;
  localparam int ST_MOUNTED = 1;
  localparam int ST_FILENO  = 2;
  localparam int ST_FTYPE   = 5;
  localparam int ST_RO      = 7;

  // Cartridge images live in slot 2 and are always mounted read-only
  localparam int CART_SLOT = 2;

  // Drive numbers 0/1/4 map onto slots 0/1/2
  function automatic logic [1:0] drv_to_slot(input logic [2:0] drv);
    return {drv[2], drv[0]};
  endfunction

  function automatic logic [2:0] slot_to_drv(input logic [1:0] slot);
    return {slot[1], 1'b0, slot[0]};
  endfunction

endpackage

// File: rtl/a800_sector_dpram.sv
// True dual-port byte RAM with registered read data on both ports.
module a800_sector_dpram #(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic [AW-1:0] i_a_addr,
  input  logic [7:0]    i_a_din,
  input  logic          i_a_we,
  output logic [7:0]    o_a_dout,
  input  logic [AW-1:0] i_b_addr,
  input  logic [7:0]    i_b_din,
  input  logic          i_b_we,
  output logic [7:0]    o_b_dout
);

  logic [7:0] r_mem [0:(1<<AW)-1];
  logic [7:0] r_a_q, r_b_q;

  always_ff @(posedge clk) begin
    if (i_a_we) r_mem[i_a_addr] <= i_a_din;
    if (i_b_we) r_mem[i_b_addr] <= i_b_din;
    r_a_q <= r_mem[i_a_addr];
    r_b_q <= r_mem[i_b_addr];
  end

  assign o_a_dout = r_a_q;
  assign o_b_dout = r_b_q;

endmodule

// File: rtl/a800_sd_bridge.sv
// ZPU register interface to hps_io virtual-disk bridge: sector buffer, LBA, block handshake, mount status.
// Optional block write support is enabled with the A800_SD_WRITE_EN macro.
module a800_sd_bridge
  import a800_sd_pkg::*;
#(
  parameter int VDNUM  = 3,
  parameter int BUF_AW = 9
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [31:0]       zpu_out2,
  input  logic [31:0]       zpu_out3,
  input  logic              zpu_io_wr,
  input  logic              zpu_data_wr,
  input  logic              zpu_data_rd,
  output logic [7:0]        zpu_in2,
  output logic [31:0]       zpu_in3,
  output logic [31:0]       sd_lba,
  output logic [VDNUM-1:0]  sd_rd,
  output logic [VDNUM-1:0]  sd_wr,
  input  logic              sd_ack,
  input  logic [BUF_AW-1:0] sd_buff_addr,
  input  logic [7:0]        sd_buff_dout,
  input  logic              sd_buff_wr,
  output logic [7:0]        sd_buff_din,
  input  logic [VDNUM-1:0]  img_mounted,
  input  logic              img_readonly,
  input  logic [63:0]       img_size,
  input  logic [7:0]        ioctl_index
);

  logic              w_lba_sel;
  logic [VDNUM-1:0]  w_slot_mask;
  logic              w_wr_rise, w_buf_we, w_rd_fall;
  logic              w_blk_rd_rise, w_blk_wr_rise, w_ack_fall, w_mnt_rise;
  logic [1:0]        w_slot_hi;
  logic [7:0]        w_q_b;
  sd_state_t         r_state, w_state_nxt;
  logic [VDNUM-1:0]  r_sd_rd, r_sd_wr, w_sd_rd_nxt, w_sd_wr_nxt;
  logic              r_io_done, w_done_nxt;
  logic              r_wr_d1, r_wr_d2, r_rd_d, r_inc_pend;
  logic [BUF_AW-1:0] r_ptr;
  logic [31:0]       r_lba, r_fsize;
  logic              r_blk_rd_d, r_ack_d, r_mnt_d;
  logic              r_mounted, r_ro;
  logic [2:0]        r_fileno;
  logic [1:0]        r_ftype;

  assign w_lba_sel   = zpu_out2[LBA_SEL];
  assign w_slot_mask = {{(VDNUM-1){1'b0}}, 1'b1} << drv_to_slot(zpu_out2[DRV_LSB +: 3]);

  // data_wr is a level that may last several cycles; act once per rising edge
  assign w_wr_rise = r_wr_d1 & ~r_wr_d2;
  assign w_buf_we  = w_wr_rise & ~w_lba_sel;
  assign w_rd_fall = r_rd_d & ~zpu_data_rd;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_wr_d1    <= 1'b0;
      r_wr_d2    <= 1'b0;
      r_rd_d     <= 1'b0;
      r_inc_pend <= 1'b0;
      r_ptr      <= '0;
      r_lba      <= '0;
    end else begin
      r_wr_d1    <= zpu_data_wr;
      r_wr_d2    <= r_wr_d1;
      r_rd_d     <= zpu_data_rd;
      r_inc_pend <= w_buf_we;
      if (zpu_io_wr) r_ptr <= '0;
      else           r_ptr <= r_ptr + BUF_AW'(r_inc_pend) + BUF_AW'(w_rd_fall);
      if (w_wr_rise && w_lba_sel) r_lba <= zpu_out3;
    end
  end

  a800_sector_dpram #(.AW(BUF_AW)) u_buf (
    .clk      (clk_sys),
    .i_a_addr (sd_buff_addr),
    .i_a_din  (sd_buff_dout),
    .i_a_we   (sd_buff_wr),
    .o_a_dout (sd_buff_din),
    .i_b_addr (r_ptr),
    .i_b_din  (zpu_out3[7:0]),
    .i_b_we   (w_buf_we),
    .o_b_dout (w_q_b)
  );

  assign w_blk_rd_rise = zpu_out2[BLK_RD] & ~r_blk_rd_d;
  assign w_ack_fall    = r_ack_d & ~sd_ack;

`ifdef A800_SD_WRITE_EN
  logic r_blk_wr_d;
  always_ff @(posedge clk_sys) begin
    if (reset) r_blk_wr_d <= 1'b0;
    else       r_blk_wr_d <= zpu_out2[BLK_WR];
  end
  assign w_blk_wr_rise = zpu_out2[BLK_WR] & ~r_blk_wr_d;
  assign sd_wr         = r_sd_wr;
`else
  assign w_blk_wr_rise = 1'b0;
  assign sd_wr         = '0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_sd_rd_nxt = r_sd_rd;
    w_sd_wr_nxt = r_sd_wr;
    w_done_nxt  = r_io_done;
    case (r_state)
      IDLE: begin
        if (w_blk_rd_rise) begin
          w_sd_rd_nxt = r_sd_rd | w_slot_mask;
          w_done_nxt  = 1'b0;
          w_state_nxt = REQ;
        end else if (w_blk_wr_rise) begin
          w_sd_wr_nxt = r_sd_wr | w_slot_mask;
          w_done_nxt  = 1'b0;
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        if (sd_ack) begin
          w_sd_rd_nxt = '0;
          w_sd_wr_nxt = '0;
          w_state_nxt = XFER;
        end
      end
      XFER: begin
        if (w_ack_fall) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state   <= IDLE;
      r_sd_rd   <= '0;
      r_sd_wr   <= '0;
      r_io_done <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_sd_rd   <= w_sd_rd_nxt;
      r_sd_wr   <= w_sd_wr_nxt;
      r_io_done <= w_done_nxt;
    end
  end

  // Highest mounted slot wins when several bits rise together
  always_comb begin
    w_slot_hi = 2'd0;
    for (int i = 0; i < VDNUM; i++)
      if (img_mounted[i]) w_slot_hi = 2'(i);
  end

  assign w_mnt_rise = (|img_mounted) & ~r_mnt_d;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_blk_rd_d <= 1'b0;
      r_ack_d    <= 1'b0;
      r_mnt_d    <= 1'b0;
      r_mounted  <= 1'b0;
      r_fileno   <= '0;
      r_ftype    <= '0;
      r_ro       <= 1'b0;
      r_fsize    <= '0;
    end else begin
      r_blk_rd_d <= zpu_out2[BLK_RD];
      r_ack_d    <= sd_ack;
      r_mnt_d    <= |img_mounted;
      if (w_mnt_rise) begin
        r_fileno  <= slot_to_drv(w_slot_hi);
        r_ftype   <= ioctl_index[7:6];
        r_fsize   <= img_size[31:0];
        r_mounted <= ~r_mounted;
`ifdef A800_SD_WRITE_EN
        r_ro      <= img_readonly | img_mounted[CART_SLOT];
`else
        r_ro      <= 1'b1;
`endif
      end
    end
  end

  always_comb begin
    zpu_in2                    = '0;
    zpu_in2[ST_IO_DONE]        = r_io_done;
    zpu_in2[ST_MOUNTED]        = r_mounted;
    zpu_in2[ST_FILENO +: 3]    = r_fileno;
    zpu_in2[ST_FTYPE +: 2]     = r_ftype;
    zpu_in2[ST_RO]             = r_ro;
  end

  assign zpu_in3 = w_lba_sel ? r_fsize : {24'b0, w_q_b};
  assign sd_lba  = r_lba;
  assign sd_rd   = r_sd_rd;

  logic w_unused;
`ifdef A800_SD_WRITE_EN
  assign w_unused = &{1'b0, zpu_out2[31:6], img_size[63:32], ioctl_index[5:0]};
`else
  assign w_unused = &{1'b0, zpu_out2[31:6], zpu_out2[BLK_WR], img_size[63:32],
                      ioctl_index[5:0], r_sd_wr, img_readonly};
`endif

endmodule

// File: tb/tb_a800_sd_bridge.sv
// Self-checking bench for a800_sd_bridge: directed sequences, mount vector table, random buffer traffic vs model.
module tb_a800_sd_bridge;
  localparam int VDNUM  = 3;
  localparam int BUF_AW = 9;
`ifdef A800_SD_WRITE_EN
  localparam bit WEN = 1'b1;
`else
  localparam bit WEN = 1'b0;
`endif

  logic              clk_sys = 1'b0;
  logic              reset;
  logic [31:0]       zpu_out2, zpu_out3;
  logic              zpu_io_wr, zpu_data_wr, zpu_data_rd;
  logic [7:0]        zpu_in2;
  logic [31:0]       zpu_in3, sd_lba;
  logic [VDNUM-1:0]  sd_rd, sd_wr;
  logic              sd_ack;
  logic [BUF_AW-1:0] sd_buff_addr;
  logic [7:0]        sd_buff_dout, sd_buff_din;
  logic              sd_buff_wr;
  logic [VDNUM-1:0]  img_mounted;
  logic              img_readonly;
  logic [63:0]       img_size;
  logic [7:0]        ioctl_index;

  always #5 clk_sys = ~clk_sys;

  a800_sd_bridge #(.VDNUM(VDNUM), .BUF_AW(BUF_AW)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .zpu_out2(zpu_out2), .zpu_out3(zpu_out3),
    .zpu_io_wr(zpu_io_wr), .zpu_data_wr(zpu_data_wr), .zpu_data_rd(zpu_data_rd),
    .zpu_in2(zpu_in2), .zpu_in3(zpu_in3),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr),
    .sd_buff_din(sd_buff_din),
    .img_mounted(img_mounted), .img_readonly(img_readonly), .img_size(img_size),
    .ioctl_index(ioctl_index)
  );

  int n_chk = 0, n_fail = 0;

  // Reference model: sector buffer contents, ZPU pointer, LBA, mount toggle
  logic [7:0]  m_mem [512];
  bit          m_vld [512];
  int          m_ptr = 0;
  logic [31:0] m_lba = 0;
  logic        m_mnt = 1'b0;

  typedef struct {
    logic [2:0]  mnt;
    logic        ro_in;
    logic [63:0] size;
    logic [7:0]  idx;
    logic [2:0]  fn;
    logic [1:0]  ft;
    logic        ro;
    logic [31:0] fs;
  } mnt_vec_t;
  mnt_vec_t mv [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk_sys); #1; end
  endtask

  task automatic zpu_iowr();
    zpu_io_wr = 1'b1; tick(); zpu_io_wr = 1'b0; tick(2);
    m_ptr = 0;
  endtask

  task automatic zpu_wbyte(input logic [7:0] b, input int n);
    zpu_out2[0] = 1'b0;
    zpu_out3 = ($urandom() & 32'hFFFF_FF00) | {24'b0, b};
    zpu_data_wr = 1'b1; tick(n); zpu_data_wr = 1'b0; tick(4);
    m_mem[m_ptr] = b; m_vld[m_ptr] = 1'b1;
    m_ptr = (m_ptr + 1) % 512;
  endtask

  task automatic zpu_rbyte(input string nm, input int n);
    zpu_out2[0] = 1'b0;
    tick();
    if (m_vld[m_ptr]) chk(nm, {56'b0, zpu_in3[7:0]}, {56'b0, m_mem[m_ptr]});
    zpu_data_rd = 1'b1; tick(n); zpu_data_rd = 1'b0; tick(2);
    m_ptr = (m_ptr + 1) % 512;
  endtask

  task automatic zpu_lba(input logic [31:0] v, input int n);
    zpu_out2[0] = 1'b1; zpu_out3 = v;
    zpu_data_wr = 1'b1; tick(n); zpu_data_wr = 1'b0; tick(3);
    zpu_out2[0] = 1'b0;
    m_lba = v;
  endtask

  task automatic hps_w(input int a, input logic [7:0] d);
    sd_buff_addr = BUF_AW'(a); sd_buff_dout = d; sd_buff_wr = 1'b1; tick(); sd_buff_wr = 1'b0;
    m_mem[a] = d; m_vld[a] = 1'b1;
  endtask

  task automatic hps_r(input string nm, input int a);
    sd_buff_addr = BUF_AW'(a); tick();
    if (m_vld[a]) chk(nm, {56'b0, sd_buff_din}, {56'b0, m_mem[a]});
  endtask

  initial begin
    logic rf;
    logic [2:0] drvs [3];
    logic [2:0] masks [3];
    reset = 1'b1; zpu_out2 = '0; zpu_out3 = '0; zpu_io_wr = 0; zpu_data_wr = 0; zpu_data_rd = 0;
    sd_ack = 0; sd_buff_addr = '0; sd_buff_dout = '0; sd_buff_wr = 0;
    img_mounted = '0; img_readonly = 0; img_size = '0; ioctl_index = '0;
    for (int i = 0; i < 512; i++) begin m_mem[i] = 8'h00; m_vld[i] = 1'b0; end

    // Expected read-only flag for a non-cart, writable image
    rf = WEN ? 1'b0 : 1'b1;
    mv[0] = '{3'b010, 1'b0, 64'h16810,        8'h40, 3'd1, 2'd1, rf,   32'h16810};
    mv[1] = '{3'b100, 1'b0, 64'h1_0000_2000,  8'hC0, 3'd4, 2'd3, 1'b1, 32'h2000};
    mv[2] = '{3'b001, 1'b1, 64'h5A5,          8'h80, 3'd0, 2'd2, 1'b1, 32'h5A5};
    mv[3] = '{3'b011, 1'b0, 64'hFFFF_FFFF,    8'h3F, 3'd1, 2'd0, rf,   32'hFFFF_FFFF};
    mv[4] = '{3'b111, 1'b0, 64'h7,            8'h41, 3'd4, 2'd1, 1'b1, 32'h7};
    mv[5] = '{3'b001, 1'b0, 64'h0,            8'h00, 3'd0, 2'd0, rf,   32'h0};
    drvs  = '{3'd0, 3'd1, 3'd4};
    masks = '{3'b001, 3'b010, 3'b100};

    tick(3); reset = 1'b0; tick();
    chk("rst_in2", {56'b0, zpu_in2}, 64'h01);
    chk("rst_sd_rd", {61'b0, sd_rd}, 64'h0);
    chk("rst_sd_wr", {61'b0, sd_wr}, 64'h0);
    chk("rst_lba", {32'b0, sd_lba}, 64'h0);
    zpu_out2[0] = 1'b1; #1;
    chk("rst_fsize", {32'b0, zpu_in3}, 64'h0);
    zpu_out2[0] = 1'b0;

    // Byte write / read-back, then ptr must sit at 3
    zpu_iowr();
    zpu_wbyte(8'h11, 1); zpu_wbyte(8'h22, 3); zpu_wbyte(8'h33, 2);
    zpu_iowr();
    zpu_rbyte("rdback0", 1); zpu_rbyte("rdback1", 2); zpu_rbyte("rdback2", 1);
    zpu_wbyte(8'h44, 1);
    hps_r("ptr_after_3", 3);
    hps_r("hps_rd0", 0);

    // LBA load timing: not visible at cycle 1, visible at cycle 2
    zpu_out2[0] = 1'b1; zpu_out3 = 32'h0000_1234; zpu_data_wr = 1'b1;
    tick(); chk("lba_cyc1", {32'b0, sd_lba}, 64'h0);
    tick(); chk("lba_cyc2", {32'b0, sd_lba}, 64'h1234);
    zpu_data_wr = 1'b0; tick(3); zpu_out2[0] = 1'b0; m_lba = 32'h1234;
    zpu_wbyte(8'h55, 1);
    hps_r("lba_no_ptr_move", 4);

    // Block read handshake on each slot
    for (int k = 0; k < 3; k++) begin
      zpu_out2[5:3] = drvs[k]; zpu_out2[1] = 1'b1; tick();
      chk($sformatf("req_sd_rd%0d", k), {61'b0, sd_rd}, {61'b0, masks[k]});
      chk($sformatf("req_done%0d", k), {63'b0, zpu_in2[0]}, 64'h0);
      sd_ack = 1'b1;
      for (int j = 0; j < 10; j++) hps_w(16 + k * 16 + j, 8'($urandom()));
      chk($sformatf("ack_sd_rd%0d", k), {61'b0, sd_rd}, 64'h0);
      sd_ack = 1'b0;
      chk($sformatf("xfer_done%0d", k), {63'b0, zpu_in2[0]}, 64'h0);
      tick();
      chk($sformatf("fin_done%0d", k), {63'b0, zpu_in2[0]}, 64'h1);
      zpu_out2[1] = 1'b0; tick();
    end
    for (int j = 16; j < 26; j++) hps_r("blk_data", j);

    // Reset while in XFER
    zpu_out2[5:3] = 3'd1; zpu_out2[1] = 1'b1; tick(); zpu_out2[1] = 1'b0;
    sd_ack = 1'b1; tick(3);
    reset = 1'b1; tick(); reset = 1'b0;
    m_ptr = 0; m_lba = 0; m_mnt = 1'b0;
    chk("rstx_sd_rd", {61'b0, sd_rd}, 64'h0);
    chk("rstx_in2", {56'b0, zpu_in2}, 64'h01);
    sd_ack = 1'b0; tick(2);
    chk("rstx_ackfall_in2", {56'b0, zpu_in2}, 64'h01);
    zpu_out2[1] = 1'b1; tick();
    chk("rstx_idle_req", {61'b0, sd_rd}, 64'h2);
    sd_ack = 1'b1; tick(2); sd_ack = 1'b0; tick(); zpu_out2[1] = 1'b0; tick();

    // Block write edge
    zpu_out2[5:3] = 3'd0; zpu_out2[2] = 1'b1; tick();
`ifdef A800_SD_WRITE_EN
    chk("bw_sd_wr", {61'b0, sd_wr}, 64'h1);
    chk("bw_done", {63'b0, zpu_in2[0]}, 64'h0);
    sd_ack = 1'b1; tick(2);
    chk("bw_clr", {61'b0, sd_wr}, 64'h0);
    sd_ack = 1'b0; tick();
    chk("bw_fin", {63'b0, zpu_in2[0]}, 64'h1);
    zpu_out2[2] = 1'b0; tick();
    zpu_out2[2:1] = 2'b11; tick();
    chk("both_rd_wins", {61'b0, sd_rd}, 64'h1);
    chk("both_no_wr", {61'b0, sd_wr}, 64'h0);
    sd_ack = 1'b1; tick(2); sd_ack = 1'b0; tick(); zpu_out2[2:1] = 2'b00; tick();
`else
    chk("bw_sd_wr_tied", {61'b0, sd_wr}, 64'h0);
    chk("bw_done_stays", {63'b0, zpu_in2[0]}, 64'h1);
    tick(3);
    chk("bw_done_later", {63'b0, zpu_in2[0]}, 64'h1);
    zpu_out2[1] = 1'b1; tick();
    chk("bw_still_idle", {61'b0, sd_rd}, 64'h1);
    sd_ack = 1'b1; tick(2); sd_ack = 1'b0; tick(); zpu_out2[2:1] = 2'b00; tick();
`endif

    // Mount vector table
    for (int v = 0; v < 6; v++) begin
      img_mounted = '0; tick(2);
      img_mounted = mv[v].mnt; img_readonly = mv[v].ro_in;
      img_size = mv[v].size; ioctl_index = mv[v].idx;
      tick();
      m_mnt = ~m_mnt;
      chk($sformatf("mnt%0d_fileno", v), {61'b0, zpu_in2[4:2]}, {61'b0, mv[v].fn});
      chk($sformatf("mnt%0d_ftype", v), {62'b0, zpu_in2[6:5]}, {62'b0, mv[v].ft});
      chk($sformatf("mnt%0d_ro", v), {63'b0, zpu_in2[7]}, {63'b0, mv[v].ro});
      chk($sformatf("mnt%0d_toggle", v), {63'b0, zpu_in2[1]}, {63'b0, m_mnt});
      zpu_out2[0] = 1'b1; #1;
      chk($sformatf("mnt%0d_fsize", v), {32'b0, zpu_in3}, {32'b0, mv[v].fs});
      zpu_out2[0] = 1'b0;
      img_size = 64'hDEAD; tick(3);
      chk($sformatf("mnt%0d_held", v), {63'b0, zpu_in2[1]}, {63'b0, m_mnt});
    end
    img_mounted = '0; tick(2);

    // Pointer wrap 511 -> 0
    zpu_iowr();
    for (int i = 0; i < 511; i++) zpu_rbyte("wrap_walk", 1);
    zpu_wbyte(8'hA5, 1); zpu_wbyte(8'h5A, 2);
    hps_r("wrap_511", 511); hps_r("wrap_0", 0);

    // io_wr beats a read-strobe increment in the same cycle
    zpu_iowr(); zpu_wbyte(8'h66, 1);
    zpu_data_rd = 1'b1; tick();
    zpu_data_rd = 1'b0; zpu_io_wr = 1'b1; tick(); zpu_io_wr = 1'b0; tick(2);
    m_ptr = 0;
    zpu_wbyte(8'h77, 1);
    hps_r("iowr_prio0", 0); hps_r("iowr_prio1", 1);

    // Random buffer/LBA traffic against the model
    zpu_iowr();
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 9))
        0, 1:    zpu_wbyte(8'($urandom()), $urandom_range(1, 3));
        2, 3:    zpu_rbyte("rnd_zrd", $urandom_range(1, 3));
        4:       zpu_iowr();
        5, 6:    hps_w($urandom_range(0, 15), 8'($urandom()));
        7, 8:    hps_r("rnd_hrd", $urandom_range(0, 15));
        default: begin
          zpu_lba($urandom(), $urandom_range(1, 3));
          chk("rnd_lba", {32'b0, sd_lba}, {32'b0, m_lba});
        end
      endcase
      if (m_ptr > 15) zpu_iowr();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
